fft4_engine: RTL
================

# fft4_engine

Four-point radix-2 DIT FFT core that answers the system FSM's start/done handshake. On `start` it captures four packed complex samples and evaluates both butterfly stages through a single shared butterfly over four cycles. It then presents four registered frequency bins with a one-cycle `done` pulse. It sits between the sample registers of the top-level controller and the output multiplexer that drives `uio_out`.

## Interface
Parameters:
- `DW`, default 8: width of each real/imag component; a sample is `2*DW` bits.

Ports:
- `clk`  input  1  sole clock, rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `start`  input  1  request; accepted only in IDLE or DONE.
- `sample0_in`..`sample3_in`  input  16 each  time samples x0..x3, packed {re[15:8], im[7:0]}, two's complement.
- `freq0_out`..`freq3_out`  output  16 each  bins X0..X3, same packing, registered.
- `done`  output  1  one-cycle pulse; all four outputs updated in the same cycle.
- `busy`  output  1  high from start acceptance until the cycle before `done`.

## Operation
- States: IDLE, S1A, S1B, S2A, S2B, DONE.
- Transitions:
  - IDLE→S1A on `start`; samples latched into x regs.
  - S1A→S1B→S2A→S2B→DONE unconditionally.
  - DONE→S1A if `start`, with new samples latched; otherwise DONE→IDLE.
- S1A: butterfly(x0,x2) → a=x0+x2, b=x0−x2.
- S1B: butterfly(x1,x3) → c=x1+x3, d=x1−x3.
- S2A: butterfly(a,c) → X0=a+c, X2=a−c, held in a pending register.
- S2B: twiddle −j on d, with −j·d = (d.im, −d.re), then X1=b+(−j·d) and X3=b−(−j·d).
- At the S2B→DONE edge, all four `freqN_out` registers load simultaneously.
- The butterfly operates on re and im independently with sign extension. Internal width is DW+2 to cover two bits of growth.
- `start` in S1A..S2B is ignored: no queuing, no abort.
- Sample inputs are sampled only at acceptance; later changes have no effect on the operation in flight.
- Outputs hold their last value until the next DONE entry.

## Timing
- Reset values: state IDLE; `done`=0; `busy`=0; all `freqN_out`=16'h0000; intermediate registers 0.
- Reset mid-operation aborts immediately. Outputs return to 0 and no `done` is issued.
- Acceptance edge E0 → `done` high in the cycle after E4, i.e. latency 4 cycles.
- `busy` is high in S1A..S2B.
- Back-to-back operation: a start held high is re-accepted in DONE. Throughput is one result per 5 cycles, and `done` pulses once every 5 cycles.
- `done` is never high for two consecutive cycles.

## Configuration
- `FFT4_STAGE_SCALE_EN` defined:
  - Each stage result is arithmetically right-shifted by 1, truncating toward −inf.
  - Outputs equal the DFT divided by 4.
  - Overflow is impossible and no saturation is applied.
- `FFT4_STAGE_SCALE_EN` undefined:
  - No shift is applied; the full DW+2 result is kept.
  - On output load, each component saturates to [−2^(DW−1), 2^(DW−1)−1], i.e. [−128, 127].

## Test plan
- Impulse, scaled: x0=16'h1000, x1..x3=0, start → 4 cycles later `done`=1 for 1 cycle; all bins = 16'h0400.
- Shifted impulse, scaled: x1=16'h0800, others 0 → X0=16'h0200, X1=16'h00FE, X2=16'hFE00, X3=16'h0002.
- Alternating, scaled: re=[8,−8,8,−8], im=0 → X2=16'h0800; X0=X1=X3=16'h0000.
- Saturation, unscaled build: all samples 16'h7F00 → X0=16'h7F00, X1..X3=0. All samples 16'h8000 → X0=16'h8000.
- Handshake:
  - `start` pulsed during S1B is ignored, with exactly one `done`.
  - `start` held high → `done` at cycles 4, 9, 14 after the first acceptance.
  - Samples changed after acceptance do not affect the result.
- Reset during S2A → `done` never asserts; outputs read 0; a fresh start then completes normally.

Source files
------------

// File: rtl/fft4_engine.sv
// Four-point radix-2 DIT FFT: one shared butterfly time-multiplexed over four cycles.
// Optional macro FFT4_STAGE_SCALE_EN: halve each stage (output = DFT/4); else saturate on load.
module fft4_engine #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2*DW-1:0] sample0_in,
  input  logic [2*DW-1:0] sample1_in,
  input  logic [2*DW-1:0] sample2_in,
  input  logic [2*DW-1:0] sample3_in,
  output logic [2*DW-1:0] freq0_out,
  output logic [2*DW-1:0] freq1_out,
  output logic [2*DW-1:0] freq2_out,
  output logic [2*DW-1:0] freq3_out,
  output logic            done,
  output logic            busy
);
  localparam int IW = DW + 2;

  typedef enum logic [2:0] {IDLE, S1A, S1B, S2A, S2B, DONE} state_t;
  state_t state_q, state_d;

  logic signed [IW-1:0] x_re_q [4], x_im_q [4];
  // stage-1 results: index 0=a, 1=b, 2=c, 3=d
  logic signed [IW-1:0] st_re_q[4], st_im_q[4];
  logic signed [IW-1:0] p0_re_q, p0_im_q, p2_re_q, p2_im_q;

  logic signed [IW-1:0] p_re, p_im, q_re, q_im;
  logic signed [IW-1:0] sum_re, sum_im, dif_re, dif_im;
  logic                 accept;

  assign accept = start && (state_q == IDLE || state_q == DONE);
  assign done   = (state_q == DONE);
  assign busy   = (state_q == S1A) || (state_q == S1B) || (state_q == S2A) || (state_q == S2B);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = S1A;
      S1A:     state_d = S1B;
      S1B:     state_d = S2A;
      S2A:     state_d = S2B;
      S2B:     state_d = DONE;
      DONE:    state_d = start ? S1A : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand select for the shared butterfly; S2B applies the -j twiddle to d.
  always_comb begin
    p_re = x_re_q[0]; p_im = x_im_q[0];
    q_re = x_re_q[2]; q_im = x_im_q[2];
    case (state_q)
      S1B: begin
        p_re = x_re_q[1]; p_im = x_im_q[1];
        q_re = x_re_q[3]; q_im = x_im_q[3];
      end
      S2A: begin
        p_re = st_re_q[0]; p_im = st_im_q[0];
        q_re = st_re_q[2]; q_im = st_im_q[2];
      end
      S2B: begin
        p_re = st_re_q[1]; p_im = st_im_q[1];
        q_re = st_im_q[3]; q_im = -st_re_q[3];
      end
      default: ;
    endcase
  end

`ifdef FFT4_STAGE_SCALE_EN
  assign sum_re = IW'(((IW+1)'(p_re) + (IW+1)'(q_re)) >>> 1);
  assign sum_im = IW'(((IW+1)'(p_im) + (IW+1)'(q_im)) >>> 1);
  assign dif_re = IW'(((IW+1)'(p_re) - (IW+1)'(q_re)) >>> 1);
  assign dif_im = IW'(((IW+1)'(p_im) - (IW+1)'(q_im)) >>> 1);

  function automatic logic [DW-1:0] fit(input logic signed [IW-1:0] v);
    return v[DW-1:0];
  endfunction
`else
  assign sum_re = p_re + q_re;
  assign sum_im = p_im + q_im;
  assign dif_re = p_re - q_re;
  assign dif_im = p_im - q_im;

  // In range when all bits from the sign down to bit DW-1 agree.
  function automatic logic [DW-1:0] fit(input logic signed [IW-1:0] v);
    if (&v[IW-1:DW-1] || ~|v[IW-1:DW-1]) return v[DW-1:0];
    return v[IW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
  endfunction
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        x_re_q[i]  <= '0; x_im_q[i]  <= '0;
        st_re_q[i] <= '0; st_im_q[i] <= '0;
      end
      p0_re_q <= '0; p0_im_q <= '0; p2_re_q <= '0; p2_im_q <= '0;
      freq0_out <= '0; freq1_out <= '0; freq2_out <= '0; freq3_out <= '0;
    end else begin
      if (accept) begin
        x_re_q[0] <= IW'($signed(sample0_in[2*DW-1:DW])); x_im_q[0] <= IW'($signed(sample0_in[DW-1:0]));
        x_re_q[1] <= IW'($signed(sample1_in[2*DW-1:DW])); x_im_q[1] <= IW'($signed(sample1_in[DW-1:0]));
        x_re_q[2] <= IW'($signed(sample2_in[2*DW-1:DW])); x_im_q[2] <= IW'($signed(sample2_in[DW-1:0]));
        x_re_q[3] <= IW'($signed(sample3_in[2*DW-1:DW])); x_im_q[3] <= IW'($signed(sample3_in[DW-1:0]));
      end
      case (state_q)
        S1A: begin
          st_re_q[0] <= sum_re; st_im_q[0] <= sum_im;
          st_re_q[1] <= dif_re; st_im_q[1] <= dif_im;
        end
        S1B: begin
          st_re_q[2] <= sum_re; st_im_q[2] <= sum_im;
          st_re_q[3] <= dif_re; st_im_q[3] <= dif_im;
        end
        S2A: begin
          p0_re_q <= sum_re; p0_im_q <= sum_im;
          p2_re_q <= dif_re; p2_im_q <= dif_im;
        end
        S2B: begin
          freq0_out <= {fit(p0_re_q), fit(p0_im_q)};
          freq1_out <= {fit(sum_re),  fit(sum_im)};
          freq2_out <= {fit(p2_re_q), fit(p2_im_q)};
          freq3_out <= {fit(dif_re),  fit(dif_im)};
        end
        default: ;
      endcase
    end
  end
endmodule
